// File: rtl/airlock_sequencer.sv
// Airlock pressure/door sequencer driving the seconds counter (start + duration).
// Only one door can ever be unlocked; timer_done is ignored in the entry cycle of a pressure change.
module airlock_sequencer #(
   parameter int unsigned SEC_W        = 10,
   parameter int unsigned PRESS_SECS   = 7,
   parameter int unsigned DEPRESS_SECS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_inner,
   input  logic             req_outer,
   input  logic             door_close,
   input  logic             abort,
   input  logic             timer_done,
   output logic             timer_start,
   output logic [SEC_W-1:0] timer_seconds,
   output logic             inner_open,
   output logic             outer_open,
   output logic             pressurized,
   output logic             busy,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      StPress   = 3'd0,
      StInOpen  = 3'd1,
      StEvac    = 3'd2,
      StVent    = 3'd3,
      StOutOpen = 3'd4,
      StFill    = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic             start_q, start_d;
   logic [SEC_W-1:0] secs_q, secs_d;
   logic             inner_q, inner_d;
   logic             outer_q, outer_d;
   logic             press_q, press_d;
   logic             busy_q, busy_d;
   logic             done_ok;

   // start_q is high exactly in the entry cycle of EVAC/FILL, when the counter may be stale
   assign done_ok = timer_done & ~start_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StPress;
         start_q <= 1'b0;
         secs_q  <= '0;
         inner_q <= 1'b0;
         outer_q <= 1'b0;
         press_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         secs_q  <= secs_d;
         inner_q <= inner_d;
         outer_q <= outer_d;
         press_q <= press_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StPress: begin
            if (req_inner) begin
               state_d = StInOpen;
            end else if (req_outer) begin
               state_d = StEvac;
            end
         end
         StInOpen: begin
            if (door_close) state_d = StPress;
         end
         StEvac: begin
            if (done_ok) begin
               state_d = StVent;
            end else if (abort) begin
               state_d = StFill;
            end
         end
         StVent: begin
            if (req_outer) begin
               state_d = StOutOpen;
            end else if (req_inner) begin
               state_d = StFill;
            end
         end
         StOutOpen: begin
            if (door_close) state_d = StVent;
         end
         StFill: begin
            if (done_ok) state_d = StPress;
         end
         default: state_d = StPress;
      endcase
   end

   // Outputs are computed from the next state so that the registered copies line up with it
   always_comb begin
      start_d = 1'b0;
      secs_d  = secs_q;
      if (state_d != state_q) begin
         if (state_d == StEvac) begin
            start_d = 1'b1;
            secs_d  = SEC_W'(DEPRESS_SECS);
         end else if (state_d == StFill) begin
            start_d = 1'b1;
            secs_d  = SEC_W'(PRESS_SECS);
         end
      end
      inner_d = (state_d == StInOpen);
      outer_d = (state_d == StOutOpen);
      press_d = (state_d == StPress) || (state_d == StInOpen) || (state_d == StEvac);
      busy_d  = (state_d == StEvac) || (state_d == StFill);
   end

   assign state         = state_q;
   assign timer_start   = start_q;
   assign timer_seconds = secs_q;
   assign inner_open    = inner_q;
   assign outer_open    = outer_q;
   assign pressurized   = press_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: directed vector table, then random stimulus vs. a
// behavioural model that tracks doors, chamber side and pending pressure change.
module tb_airlock_sequencer;

   localparam int unsigned SEC_W = 10;
   localparam int unsigned PS    = 7;
   localparam int unsigned DS    = 8;

   logic             clk = 1'b0;
   logic             reset, req_inner, req_outer, door_close, abort, timer_done;
   logic             timer_start, inner_open, outer_open, pressurized, busy;
   logic [SEC_W-1:0] timer_seconds;
   logic [2:0]       state;

   int checks = 0;
   int errors = 0;

   airlock_sequencer #(
      .SEC_W       (SEC_W),
      .PRESS_SECS  (PS),
      .DEPRESS_SECS(DS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_inner    (req_inner),
      .req_outer    (req_outer),
      .door_close   (door_close),
      .abort        (abort),
      .timer_done   (timer_done),
      .timer_start  (timer_start),
      .timer_seconds(timer_seconds),
      .inner_open   (inner_open),
      .outer_open   (outer_open),
      .pressurized  (pressurized),
      .busy         (busy),
      .state        (state)
   );

   always #5 clk = ~clk;

   // inputs: reset, req_inner, req_outer, door_close, abort, timer_done
   typedef struct {
      logic [5:0] in;
      logic [2:0] st;
      logic       start;
      int         secs;
      logic       inr;
      logic       outr;
      logic       pr;
      logic       bsy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [5:0] in, logic [2:0] st, logic start, int secs,
                               logic inr, logic outr, logic pr, logic bsy);
      vec_t v;
      v.in = in; v.st = st; v.start = start; v.secs = secs;
      v.inr = inr; v.outr = outr; v.pr = pr; v.bsy = bsy;
      return v;
   endfunction

   // Behavioural model: door 0 none/1 inner/2 outer; side 1 cabin, 0 vacuum;
   // change 0 none/1 evacuating/2 filling; age = cycles spent in the change.
   int m_door, m_side, m_change, m_age, m_secs, m_start;

   function automatic void model_step(logic [5:0] in);
      logic rst, ri, ro, dc, ab, td;
      {rst, ri, ro, dc, ab, td} = in;
      m_start = 0;
      if (rst) begin
         m_door = 0; m_side = 1; m_change = 0; m_age = 0; m_secs = 0;
      end else if (m_change != 0) begin
         if (td && m_age > 0) begin
            m_side   = (m_change == 1) ? 0 : 1;
            m_change = 0;
         end else if (m_change == 1 && ab) begin
            m_change = 2; m_age = 0; m_secs = PS; m_start = 1;
         end else begin
            m_age++;
         end
      end else if (m_door != 0) begin
         if (dc) m_door = 0;
      end else if (m_side == 1) begin
         if (ri) m_door = 1;
         else if (ro) begin
            m_change = 1; m_age = 0; m_secs = DS; m_start = 1;
         end
      end else begin
         if (ro) m_door = 2;
         else if (ri) begin
            m_change = 2; m_age = 0; m_secs = PS; m_start = 1;
         end
      end
   endfunction

   function automatic vec_t model_exp(logic [5:0] in);
      vec_t v;
      v.in    = in;
      v.st    = (m_change == 1) ? 3'd2 : (m_change == 2) ? 3'd5 :
                (m_door == 1) ? 3'd1 : (m_door == 2) ? 3'd4 : (m_side == 1) ? 3'd0 : 3'd3;
      v.start = (m_start != 0);
      v.secs  = m_secs;
      v.inr   = (m_door == 1);
      v.outr  = (m_door == 2);
      v.pr    = (m_change == 1) || (m_change == 0 && m_side == 1);
      v.bsy   = (m_change != 0);
      return v;
   endfunction

   task automatic apply(logic [5:0] in);
      @(negedge clk);
      {reset, req_inner, req_outer, door_close, abort, timer_done} = in;
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, vec_t e);
      logic [17:0] got, exp;
      got = {state, timer_start, timer_seconds, inner_open, outer_open, pressurized, busy};
      exp = {e.st, e.start, SEC_W'(e.secs), e.inr, e.outr, e.pr, e.bsy};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got st=%0d start=%0b secs=%0d in=%0b out=%0b pr=%0b busy=%0b, expected st=%0d start=%0b secs=%0d in=%0b out=%0b pr=%0b busy=%0b",
                  name, state, timer_start, timer_seconds, inner_open, outer_open, pressurized,
                  busy, e.st, e.start, e.secs, e.inr, e.outr, e.pr, e.bsy);
      end
      checks++;
      if ((inner_open & outer_open) || (inner_open & ~pressurized)) begin
         errors++;
         $display("FAIL %s door_interlock: got in=%0b out=%0b pr=%0b, expected no conflict",
                  name, inner_open, outer_open, pressurized);
      end
   endtask

   initial begin
      {reset, req_inner, req_outer, door_close, abort, timer_done} = 6'b100000;

      // in = {reset, req_inner, req_outer, door_close, abort, timer_done}
      vecs.push_back(mk(6'b100000, 0, 0, 0, 0, 0, 1, 0)); // reset
      vecs.push_back(mk(6'b000000, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(6'b010000, 1, 0, 0, 1, 0, 1, 0)); // inner door
      vecs.push_back(mk(6'b011000, 1, 0, 0, 1, 0, 1, 0)); // requests ignored
      vecs.push_back(mk(6'b000100, 0, 0, 0, 0, 0, 1, 0)); // door_close
      vecs.push_back(mk(6'b000010, 0, 0, 0, 0, 0, 1, 0)); // stray abort
      vecs.push_back(mk(6'b001000, 2, 1, 8, 0, 0, 1, 1)); // evac load
      vecs.push_back(mk(6'b000001, 2, 0, 8, 0, 0, 1, 1)); // stale done ignored
      vecs.push_back(mk(6'b000000, 2, 0, 8, 0, 0, 1, 1));
      vecs.push_back(mk(6'b000001, 3, 0, 8, 0, 0, 0, 0)); // vented
      vecs.push_back(mk(6'b000100, 3, 0, 8, 0, 0, 0, 0)); // stray door_close
      vecs.push_back(mk(6'b001000, 4, 0, 8, 0, 1, 0, 0)); // outer door
      vecs.push_back(mk(6'b001000, 4, 0, 8, 0, 1, 0, 0));
      vecs.push_back(mk(6'b000100, 3, 0, 8, 0, 0, 0, 0));
      vecs.push_back(mk(6'b010000, 5, 1, 7, 0, 0, 0, 1)); // fill load
      vecs.push_back(mk(6'b000011, 5, 0, 7, 0, 0, 0, 1)); // entry done + abort ignored
      vecs.push_back(mk(6'b000010, 5, 0, 7, 0, 0, 0, 1)); // abort ignored in fill
      vecs.push_back(mk(6'b000001, 0, 0, 7, 0, 0, 1, 0)); // filled
      vecs.push_back(mk(6'b001000, 2, 1, 8, 0, 0, 1, 1));
      vecs.push_back(mk(6'b000000, 2, 0, 8, 0, 0, 1, 1));
      vecs.push_back(mk(6'b000000, 2, 0, 8, 0, 0, 1, 1));
      vecs.push_back(mk(6'b000010, 5, 1, 7, 0, 0, 0, 1)); // abort 3 cycles in
      vecs.push_back(mk(6'b000001, 5, 0, 7, 0, 0, 0, 1)); // entry cycle done ignored
      vecs.push_back(mk(6'b000001, 0, 0, 7, 0, 0, 1, 0));
      vecs.push_back(mk(6'b001000, 2, 1, 8, 0, 0, 1, 1));
      vecs.push_back(mk(6'b000000, 2, 0, 8, 0, 0, 1, 1));
      vecs.push_back(mk(6'b000011, 3, 0, 8, 0, 0, 0, 0)); // done beats abort
      vecs.push_back(mk(6'b010000, 5, 1, 7, 0, 0, 0, 1));
      vecs.push_back(mk(6'b000000, 5, 0, 7, 0, 0, 0, 1));
      vecs.push_back(mk(6'b101001, 0, 0, 0, 0, 0, 1, 0)); // reset mid fill wins
      vecs.push_back(mk(6'b000001, 0, 0, 0, 0, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].in);
         check($sformatf("vec%0d", i), vecs[i]);
      end

      // Idle for 20 cycles after reset
      for (int i = 0; i < 20; i++) begin
         apply(6'b000000);
         check($sformatf("idle%0d", i), mk(6'b0, 0, 0, 0, 0, 0, 1, 0));
      end

      // Full evac cycle with an 8-cycle timer model driving timer_done
      apply(6'b001000);
      check("seq_evac_load", mk(6'b0, 2, 1, 8, 0, 0, 1, 1));
      for (int i = 0; i < 7; i++) begin
         apply(6'b000000);
         check($sformatf("seq_evac_wait%0d", i), mk(6'b0, 2, 0, 8, 0, 0, 1, 1));
      end
      apply(6'b000001);
      check("seq_evac_done", mk(6'b0, 3, 0, 8, 0, 0, 0, 0));
      apply(6'b100000);

      // Randomized stimulus against the behavioural model
      model_step(6'b100000);
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] in;
         vec_t       e;
         in[5] = ($urandom_range(0, 199) == 0);
         in[4] = ($urandom_range(0, 3) == 0);
         in[3] = ($urandom_range(0, 3) == 0);
         in[2] = ($urandom_range(0, 4) == 0);
         in[1] = ($urandom_range(0, 5) == 0);
         in[0] = ($urandom_range(0, 4) == 0);
         apply(in);
         model_step(in);
         e = model_exp(in);
         check($sformatf("rand%0d", i), e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
